// File: rtl/zuss_lsu_ctrl.sv
// Load/store unit controller: one outstanding RV32I access against a synchronous-read
// data memory, with byte-lane write enables and sign/zero-extended load return.
module zuss_lsu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_out
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    logic        legal_f3, misal, err;
    logic [3:0]  store_we;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_data;

    // Request decode, all from the captured registers.
    always_comb begin
        if (we_q) legal_f3 = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010);
        else      legal_f3 = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010) ||
                             (f3_q == 3'b100) || (f3_q == 3'b101);
        misal = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        err   = !legal_f3 || misal;
    end

    always_comb begin
        case (f3_q[1:0])
            2'b00:   begin store_we = 4'b0001 << addr_q[1:0]; mem_data = {4{wdata_q[7:0]}};  end
            2'b01:   begin store_we = addr_q[1] ? 4'b1100 : 4'b0011; mem_data = {2{wdata_q[15:0]}}; end
            default: begin store_we = 4'b1111; mem_data = wdata_q; end
        endcase
    end

    always_comb begin
        ld_b = mem_out[{addr_q[1:0], 3'b000} +: 8];
        ld_h = mem_out[{addr_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
            3'b100:  ld_data = {24'h0, ld_b};
            3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
            3'b101:  ld_data = {16'h0, ld_h};
            default: ld_data = mem_out;
        endcase
    end

    assign mem_addr = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = (err || we_q) ? RESP : WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // mem_we is gated by rst directly so a write cannot slip out before state clears.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        mem_we     = 4'b0000;
        if (state == ISSUE && !rst && we_q && !err) mem_we = store_we;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    f3_q    <= req_funct3;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                end
                ISSUE: begin
                    resp_err   <= err;
                    resp_rdata <= 32'h0;
                end
                WAIT: begin
                    resp_err   <= 1'b0;
                    resp_rdata <= ld_data;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/zuss_lsu_ctrl.md
ZUSS_LSU_CTRL -- requirements
Module: ZUSS_LSU_CTRL

Interface
REQ-001 The block SHALL have no parameters; widths are fixed (32-bit address/data, 4 byte lanes).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL have the following ports, with clock and reset first:
- clk  in  1  -- clock; all state updates on the rising edge.
- rst  in  1  -- asynchronous active-high reset.
- req_valid  in  1  -- request present.
- req_ready  out  1  -- controller can accept a request.
- req_we  in  1  -- 1 = store, 0 = load.
- req_funct3  in  3  -- RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  -- byte address.
- req_wdata  in  32  -- store data, right-aligned.
- resp_valid  out  1  -- response present.
- resp_ready  in  1  -- consumer accepts the response.
- resp_rdata  out  32  -- load result, extended; 0 for stores and errors.
- resp_err  out  1  -- misaligned address or illegal funct3.
- mem_addr  out  32  -- address to the data memory.
- mem_data  out  32  -- lane-replicated write data.
- mem_we  out  4  -- per-byte-lane write enables.
- mem_out  in  32  -- memory read data; synchronous read, valid one edge after mem_addr.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-005 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-006 On acceptance, the block SHALL capture we, funct3, addr and wdata into internal registers and move IDLE->ISSUE.
REQ-007 mem_addr SHALL always equal the captured address; mem_data SHALL always be derived from the captured wdata and funct3.
REQ-008 Legality SHALL be determined as follows:
- Load legal funct3: 000, 001, 010, 100, 101.
- Store legal funct3: 000, 001, 010.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=00.
- Any illegal or misaligned request is an error.
REQ-009 In ISSUE, for a legal store, mem_we SHALL be: B = 4'b0001<<addr[1:0]; H = addr[1] ? 1100 : 0011; W = 1111.
REQ-010 mem_we SHALL be 0000 in every state other than ISSUE, and in ISSUE for any load or error.
REQ-011 mem_data SHALL be: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
REQ-012 ISSUE transitions SHALL be:
- error -> RESP, with resp_err=1 and resp_rdata=0;
- legal store -> RESP, with resp_rdata=0;
- legal load -> WAIT.
REQ-013 In WAIT, the block SHALL register the extracted load data into resp_rdata and go to RESP.
- Byte lane = mem_out[8*addr[1:0]+:8]; halfword = mem_out[16*addr[1]+:16].
- B/H sign-extend; BU/HU zero-extend; W passes through.
REQ-014 In RESP, resp_valid SHALL be 1, and resp_rdata and resp_err SHALL be held stable; RESP->IDLE on the edge where resp_ready=1.
REQ-015 Latency, counting edges after the accepting edge until resp_valid=1, SHALL be: load 2, store 1, error 1.
REQ-016 The next request SHALL NOT be accepted in the same cycle the response is consumed.
- Minimum request spacing: 3 cycles for stores/errors, 4 cycles for loads.
REQ-017 Back-pressure: resp_ready held 0 SHALL keep the FSM in RESP indefinitely, with no further mem_we activity.
REQ-018 req_* inputs SHALL be ignored outside IDLE; the captured request registers SHALL NOT change outside the accepting edge.

Reset
REQ-019 While rst=1, the block SHALL hold all state as follows, independent of clk:
- state = IDLE;
- resp_valid = 0, resp_err = 0, resp_rdata = 0;
- captured registers = 0, hence mem_addr = 0 and mem_data = 0;
- mem_we = 0000.
REQ-020 Reset asserted in ISSUE SHALL suppress mem_we immediately (combinational from state), so no partial write occurs after rst rises.
REQ-021 A response pending at reset SHALL be discarded; after rst falls, req_ready=1 on the first cycle.

Verification
REQ-022 SW then LW: SW addr=0x10, wdata=0xDEADBEEF -> mem_we=1111 in ISSUE and resp_valid 1 edge later with err=0; LW addr=0x10 -> resp_rdata=0xDEADBEEF after 2 edges.
REQ-023 Byte lanes: SB addr=0x13, wdata=0x000000A5 -> mem_we=1000, mem_data=0xA5A5A5A5; LB addr=0x13 -> 0xFFFFFFA5; LBU addr=0x13 -> 0x000000A5.
REQ-024 Halfword: SH addr=0x22, wdata=0x00008001 -> mem_we=1100; LH addr=0x22 -> 0xFFFF8001; LHU addr=0x22 -> 0x00008001.
REQ-025 Errors:
- LW addr=0x11 -> resp_err=1, resp_rdata=0, 1-edge latency, no WAIT.
- SW addr=0x12 -> mem_we stays 0000 and memory is unchanged.
- Load with funct3=011 -> resp_err=1.
REQ-026 Back-pressure: resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable; req_ready=0 throughout; a new req_valid is ignored until the cycle after the handshake.
REQ-027 Reset mid-operation: rst pulsed while in ISSUE of SW addr=0x30 -> mem_we=0000 from rst rise; word 0x30 is unchanged on readback; outputs hold reset values.
